// File: rtl/apb_pkg.sv
// Shared types for the APB3 requester bridge: FSM states, bus widths and the
// response record returned to the command side.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; flags the last permitted ACCESS wait cycle.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Keep at least one bit so a disabled watchdog still elaborates cleanly.
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: accepts one valid/ready command, runs a single SETUP/ACCESS
// transfer with a wait-state watchdog and returns the outcome on a response channel.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              _PCLK,
  input  logic              _PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              _PSEL1,
  output logic              _PENABLE,
  output logic              _PWRITE,
  output logic [ADDR_W-1:0] _PADDR,
  output logic [DATA_W-1:0] _PWDATA,
  input  logic [DATA_W-1:0] _PRDATA,
  input  logic              _PREADY,
  input  logic              _PSLVERR
);

  apb_mst_state_t state;
  apb_rsp_t       rsp_q;
  logic           expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (_PCLK),
    .rst    (_PRESET),
    .clear  (state != ACCESS),
    .enable ((state == ACCESS) && !_PREADY),
    .expired(expired)
  );

  always_ff @(posedge _PCLK) begin
    if (_PRESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      _PSEL1    <= 1'b0;
      _PENABLE  <= 1'b0;
      _PWRITE   <= 1'b0;
      _PADDR    <= '0;
      _PWDATA   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          _PSEL1    <= 1'b0;
          _PENABLE  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            _PWRITE   <= cmd_write;
            _PADDR    <= cmd_addr;
            _PWDATA   <= cmd_wdata;
            _PSEL1    <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          _PENABLE <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A completing handshake beats the watchdog in the same cycle.
          if (_PREADY) begin
            rsp_q.slverr  <= _PSLVERR;
            rsp_q.timeout <= 1'b0;
            rsp_q.rdata   <= (!_PWRITE && !_PSLVERR) ? APB_DATA_W'(_PRDATA) : '0;
            _PSEL1        <= 1'b0;
            _PENABLE      <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (expired) begin
            rsp_q.slverr  <= 1'b1;
            rsp_q.timeout <= 1'b1;
            rsp_q.rdata   <= '0;
            _PSEL1        <= 1'b0;
            _PENABLE      <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
  assign rsp_slverr  = rsp_q.slverr;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 requester (initiator) that turns a simple valid/ready command stream into single APB transfers.
- Drives the existing APB slave memory and any future APB3 completers on the same bus.
- Returns read data, slave error and timeout status on a valid/ready response channel.
- Executes one outstanding transfer at a time, with a bounded wait-state watchdog.

Parameters:
- ADDR_W, 32, width of command address and _PADDR
- DATA_W, 32, width of write/read data
- TIMEOUT_CYCLES, 64, maximum ACCESS cycles with _PREADY low before abort; 0 disables the watchdog

Ports:
- _PCLK  in  1  clock, all logic on rising edge
- _PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data
- rsp_slverr  out  1  completer error or timeout
- rsp_timeout  out  1  transfer aborted by the watchdog
- _PSEL1  out  1  APB select
- _PENABLE  out  1  APB enable
- _PWRITE  out  1  APB direction
- _PADDR  out  ADDR_W  APB address
- _PWDATA  out  DATA_W  APB write data
- _PRDATA  in  DATA_W  APB read data
- _PREADY  in  1  completer ready
- _PSLVERR  in  1  completer error

Behaviour:
- Reset (synchronous, _PRESET=1 at a clock edge):
  - State goes to IDLE.
  - Every output is 0: _PSEL1, _PENABLE, _PWRITE, _PADDR, _PWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout.
  - The wait counter is cleared.
  - Reset takes priority over every other event, including mid-ACCESS. The bus drops _PSEL1/_PENABLE on that edge and no response is produced for the aborted transfer.
- States:
  - IDLE
    - cmd_ready=1 (registered, so it is high the cycle after reset deasserts).
    - On cmd_valid&&cmd_ready: register cmd_write/addr/wdata onto _PWRITE/_PADDR/_PWDATA, then go to SETUP.
    - While in IDLE, the bus outputs hold their last values and _PSEL1=0.
  - SETUP
    - _PSEL1=1, _PENABLE=0, cmd_ready=0.
    - Always goes to ACCESS after 1 cycle.
  - ACCESS
    - _PSEL1=1, _PENABLE=1.
    - _PADDR, _PWRITE and _PWDATA stay stable throughout, because the completer decodes them combinationally.
    - Wait counter increments on each ACCESS cycle with _PREADY=0.
    - When _PREADY=1:
      - rsp_slverr is set from _PSLVERR.
      - rsp_rdata is set from _PRDATA, only for a read with _PSLVERR=0; otherwise rsp_rdata=0.
      - rsp_timeout=0; go to RESP.
    - Timeout: if TIMEOUT_CYCLES!=0, _PREADY=0 and the counter equals TIMEOUT_CYCLES-1, then rsp_timeout=1, rsp_slverr=1, rsp_rdata=0; go to RESP.
    - _PREADY wins over timeout when both occur in the same cycle.
  - RESP
    - _PSEL1=0, _PENABLE=0, rsp_valid=1.
    - Response fields stay stable until rsp_valid&&rsp_ready.
    - After that handshake: rsp_valid=0, go to IDLE, counter cleared.
- Latency: with a zero-wait completer and rsp_ready=1, the command is accepted at cycle N, SETUP is N+1, ACCESS is N+2, rsp_valid is N+3, and cmd_ready is high again at N+4. One transfer is in flight at most.
- _PSLVERR is sampled only when _PSEL1&&_PENABLE&&_PREADY. It is ignored at all other times.
- The counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- Address is passed through unmodified. Out-of-range addresses are the completer's concern.

Decomposition:
- Shared package apb_pkg holds:
  - state enum apb_mst_state_t {IDLE, SETUP, ACCESS, RESP}
  - APB_ADDR_W=32, APB_DATA_W=32
  - response struct {rdata, slverr, timeout}
- One sub-module, apb_wait_timer: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write 0x0000_1234 to 0x10, then read 0x10 -> write response slverr=0; read response rdata=0x0000_1234, slverr=0, timeout=0.
- Write to 60 (read-only location) -> rsp_slverr=1, rsp_rdata=0; a following read of 60 returns 60 (init value), slverr=0.
- Read from 25 (write-only location) -> rsp_slverr=1, rsp_rdata=0. Read of 0x10000 -> rsp_slverr=1.
- Completer model with _PREADY held low, TIMEOUT_CYCLES=8 -> exactly 8 ACCESS cycles, then rsp_timeout=1, rsp_slverr=1, _PSEL1=0 on the next cycle.
- rsp_ready held low 5 cycles after a read of 0x5 -> rsp_valid and rsp_rdata=5 stable for 5 cycles, cmd_ready=0 throughout, and a new cmd_valid is not accepted.
- _PRESET asserted during ACCESS with 3 wait states pending -> next edge _PSEL1=0, _PENABLE=0, rsp_valid=0, cmd_ready=1 one cycle after release, and the next command completes normally.
